attn_residual_stream: RTL and testbench
=======================================

Name: attn_residual_stream

Overview:
- Downstream neighbour of the self-attention top. Consumes its (L,E) Q1.15 output array when that block signals done/out_valid.
- Adds the original input x_in as a residual, with saturating Q1.15 addition.
- Streams the result one token row (E elements) per beat over a valid/ready handshake to the next stage (norm/FFN).
- Decouples the array-at-once attention output from row-serial downstream consumers.

Parameters:
- DATA_WIDTH, 16, element width (Q1.15).
- L, 16, sequence length (rows).
- E, 32, embedding dimension (elements per row).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  capture request; driven by attention done/out_valid.
- attn_in  in  DATA_WIDTH x [L*E]  attention output, row-major.
- x_in  in  DATA_WIDTH x [L*E]  residual input, row-major.
- busy  out  1  high from capture until done.
- row_valid  out  1  output row valid.
- row_ready  in  1  downstream ready.
- row_data  out  DATA_WIDTH x [E]  current row.
- row_idx  out  $clog2(L)  index of current row.
- row_last  out  1  high with row_valid when row_idx==L-1.
- done  out  1  one-cycle pulse after last row accepted.
- sat_count  out  16  (only with RESID_SAT_CNT_EN) saturations this pass.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values: state=IDLE; busy=0, row_valid=0, row_last=0, done=0, row_idx=0, row_data all 0; internal sum buffer all 0.
- States: IDLE, STREAM, DONE.
- IDLE:
  - start=1 at edge T captures sat(attn_in[i]+x_in[i]) for all i into sum buffer, and loads row_data with buffer row 0 (computed directly from inputs).
  - T+1: state=STREAM, busy=1, row_valid=1, row_idx=0.
  - Input arrays are sampled only at T and may change afterwards.
- STREAM:
  - row_valid=1. While row_ready=0, row_data/row_idx/row_last stay stable.
  - Handshake (valid&ready) on row r<L-1: next cycle row_idx=r+1, row_data=buffer row r+1.
  - Handshake on row L-1: next cycle state=DONE, row_valid=0, done=1.
- DONE: done=1, busy=1 for exactly one cycle; then IDLE, busy=0.
- start outside IDLE is ignored (no recapture, no error). Earliest restart: first IDLE cycle, i.e. 2 cycles after last handshake.
- Throughput: 1 row/cycle under continuous ready; full pass = L beats + 2 cycles overhead.
- Arithmetic, per element:
  - 17-bit signed sum s=a+b.
  - If s[16]!=s[15]: clamp to 16'h7FFF when s[16]=0, to 16'h8000 when s[16]=1.
  - Otherwise take s[15:0]. No rounding.
- rst mid-pass: immediate return to reset values on the next edge. Partial stream is abandoned; no done pulse.
- L=1: row_last is high on the first beat; the single handshake goes straight to DONE.

Optional Feature:
- RESID_SAT_CNT_EN defined:
  - sat_count port exists and is cleared to 0 at the capture edge.
  - It is loaded with the number of clamped elements among the L*E captured, saturating at 16'hFFFF.
  - It holds until the next capture; reset value 0.
- Undefined: no sat_count port and no counting logic. All other behaviour is identical.

Decomposition:
- Shared package attn_pkg:
  - Q15_MAX=16'h7FFF, Q15_MIN=16'h8000.
  - typedef enum resid_state_t {IDLE, STREAM, DONE}.
- Sub-module q15_sat_add: combinational saturating adder (a, b -> y, sat flag), instantiated L*E times at capture.

Test Plan:
- Basic pass: attn=16'h1000, x=16'h0800 everywhere, row_ready=1. Expect rows 0..15 on consecutive cycles, all elements 16'h1800, row_last on beat 16, done one cycle after, busy low the next cycle.
- Saturation: attn[0]=16'h7000 + x[0]=16'h2000 -> 16'h7FFF; attn[1]=16'h9000 + x[1]=16'hD000 -> 16'h8000; attn[2]=16'hFFFF + x[2]=16'h0001 -> 16'h0000. With RESID_SAT_CNT_EN, sat_count=2.
- Backpressure: row_ready=0 for 5 cycles on row 3. row_data/row_idx=3 stay stable, no skipped or duplicated rows, total beats=16.
- Start while busy: pulse start with different inputs during row 7. Stream continues with the original data and only one done pulse occurs.
- Reset mid-stream: assert rst at row 9. Next cycle row_valid=0, busy=0, row_idx=0, no done. A new start then streams from row 0 with the new data.
- Input change after capture: modify attn_in the cycle after start. Output reflects only the captured values.

Source files
------------

// File: rtl/attn_pkg.sv
// Shared types and Q1.15 constants for the attention residual stream.
package attn_pkg;

    localparam logic [15:0] Q15_MAX = 16'h7FFF;
    localparam logic [15:0] Q15_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } resid_state_t;

endpackage

// File: rtl/q15_sat_add.sv
// Combinational saturating signed adder; the sat flag exists only when
// RESID_SAT_CNT_EN is defined.
module q15_sat_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
`ifdef RESID_SAT_CNT_EN
    ,
    output logic         sat
`endif
);

    localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    logic [W:0] sum;
    logic       ovf;

    // Overflow is exactly when the sign-extension bit disagrees with the result sign.
    assign sum = {a[W-1], a} + {b[W-1], b};
    assign ovf = sum[W] ^ sum[W-1];
    assign y   = ovf ? (sum[W] ? MIN_VAL : MAX_VAL) : sum[W-1:0];

`ifdef RESID_SAT_CNT_EN
    assign sat = ovf;
`endif

endmodule

// File: rtl/attn_residual_stream.sv
// Captures sat(attn_in + x_in) for a whole (L,E) array and streams it row by row
// over valid/ready. Optional saturation counter: define RESID_SAT_CNT_EN.
module attn_residual_stream
    import attn_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int L          = 16,
    parameter  int E          = 32,
    localparam int IDX_W      = (L > 1) ? $clog2(L) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [L*E-1:0][DATA_WIDTH-1:0]   attn_in,
    input  logic [L*E-1:0][DATA_WIDTH-1:0]   x_in,
    output logic                             busy,
    output logic                             row_valid,
    input  logic                             row_ready,
    output logic [E-1:0][DATA_WIDTH-1:0]     row_data,
    output logic [IDX_W-1:0]                 row_idx,
    output logic                             row_last,
    output logic                             done
`ifdef RESID_SAT_CNT_EN
    ,
    output logic [15:0]                      sat_count
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(L - 1);

    resid_state_t                             state;
    logic [L-1:0][E-1:0][DATA_WIDTH-1:0]      sum_all;
    logic [L-1:0][E-1:0][DATA_WIDTH-1:0]      sum_buf;
    logic [IDX_W-1:0]                         next_idx;

`ifdef RESID_SAT_CNT_EN
    logic [L-1:0][E-1:0]                      sat_all;
    logic [31:0]                              sat_total;
    logic [15:0]                              sat_next;
`endif

    for (genvar r = 0; r < L; r++) begin : g_row
        for (genvar c = 0; c < E; c++) begin : g_col
            q15_sat_add #(.W(DATA_WIDTH)) u_add (
                .a   (attn_in[r*E + c]),
                .b   (x_in[r*E + c]),
                .y   (sum_all[r][c])
`ifdef RESID_SAT_CNT_EN
                ,
                .sat (sat_all[r][c])
`endif
            );
        end
    end

`ifdef RESID_SAT_CNT_EN
    always_comb begin
        sat_total = '0;
        for (int r = 0; r < L; r++) begin
            for (int c = 0; c < E; c++) begin
                sat_total = sat_total + 32'(sat_all[r][c]);
            end
        end
        sat_next = (sat_total > 32'h0000_FFFF) ? 16'hFFFF : sat_total[15:0];
    end
`endif

    assign next_idx = row_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            row_valid <= 1'b0;
            row_last  <= 1'b0;
            done      <= 1'b0;
            row_idx   <= '0;
            row_data  <= '0;
            // NOTE: the capture buffer is cleared as well, so a reset leaves no stale pass data behind.
            sum_buf   <= '0;
`ifdef RESID_SAT_CNT_EN
            sat_count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        sum_buf   <= sum_all;
                        row_data  <= sum_all[0];
                        row_idx   <= '0;
                        row_last  <= (L == 1);
                        row_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= STREAM;
`ifdef RESID_SAT_CNT_EN
                        sat_count <= sat_next;
`endif
                    end
                end
                STREAM: begin
                    if (row_ready) begin
                        if (row_idx == LAST_IDX) begin
                            row_valid <= 1'b0;
                            row_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            row_idx  <= next_idx;
                            row_data <= sum_buf[next_idx];
                            row_last <= (next_idx == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_attn_residual_stream.sv
// Scoreboard bench: stimulus pushes expected rows, a negedge monitor pops and compares.
// Build with RESID_SAT_CNT_EN defined to also check sat_count.
module tb_attn_residual_stream;
    import attn_pkg::*;

    localparam int DW    = 16;
    localparam int L     = 16;
    localparam int E     = 32;
    localparam int IDX_W = $clog2(L);
    localparam int CW    = E * DW;

    typedef struct {
        int                    idx;
        logic                  last;
        logic [E-1:0][DW-1:0]  data;
    } exp_row_t;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         start;
    logic [L*E-1:0][DW-1:0]       attn_in;
    logic [L*E-1:0][DW-1:0]       x_in;
    logic                         busy;
    logic                         row_valid;
    logic                         row_ready;
    logic [E-1:0][DW-1:0]         row_data;
    logic [IDX_W-1:0]             row_idx;
    logic                         row_last;
    logic                         done;
`ifdef RESID_SAT_CNT_EN
    logic [15:0]                  sat_count;
`endif

    exp_row_t sb[$];
    exp_row_t mon_e;
    int checks   = 0;
    int errors   = 0;
    int beats    = 0;
    int done_cnt = 0;

    attn_residual_stream #(.DATA_WIDTH(DW), .L(L), .E(E)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .attn_in   (attn_in),
        .x_in      (x_in),
        .busy      (busy),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .row_idx   (row_idx),
        .row_last  (row_last),
        .done      (done)
`ifdef RESID_SAT_CNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && row_valid && row_ready) begin
            beats++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_row: got row %0d with nothing expected", row_idx);
            end else begin
                mon_e = sb.pop_front();
                check("row_data", row_data, mon_e.data);
                check("row_idx", CW'(row_idx), CW'(mon_e.idx));
                check("row_last", CW'(row_last), CW'(mon_e.last));
            end
        end
        if (!rst && done) done_cnt++;
    end

    task automatic push_row(input int r, input logic [E-1:0][DW-1:0] d);
        exp_row_t e;
        e.idx  = r;
        e.last = (r == L - 1);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic push_uniform(input logic [DW-1:0] v);
        for (int r = 0; r < L; r++) push_row(r, {E{v}});
    endtask

    task automatic fill(input logic [DW-1:0] a, input logic [DW-1:0] x);
        for (int i = 0; i < L*E; i++) begin
            attn_in[i] = a;
            x_in[i]    = x;
        end
    endtask

    task automatic do_start();
        beats    = 0;
        done_cnt = 0;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen_before_timeout", CW'(done), CW'(1));
    endtask

    task automatic wait_idx(input int k);
        int n = 0;
        while (!(row_valid && row_idx == IDX_W'(k)) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("row_reached_before_timeout", CW'(row_idx), CW'(k));
    endtask

    task automatic finish_pass(input int exp_beats);
        @(posedge clk); #1;
        check("busy_low_after_done", CW'(busy), CW'(0));
        check("done_single_cycle", CW'(done), CW'(0));
        check("beat_count", CW'(beats), CW'(exp_beats));
        check("done_pulse_count", CW'(done_cnt), CW'(1));
        check("scoreboard_drained", CW'(sb.size()), CW'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [E-1:0][DW-1:0] d;
        logic [E-1:0][DW-1:0] hold;

        rst = 1'b1; start = 1'b0; row_ready = 1'b1;
        fill(16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", CW'(busy), CW'(0));
        check("reset_row_valid", CW'(row_valid), CW'(0));
        check("reset_row_last", CW'(row_last), CW'(0));
        check("reset_done", CW'(done), CW'(0));
        check("reset_row_idx", CW'(row_idx), CW'(0));
        check("reset_row_data", row_data, '0);
`ifdef RESID_SAT_CNT_EN
        check("reset_sat_count", CW'(sat_count), CW'(0));
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic pass: 0x1000 + 0x0800 = 0x1800 everywhere.
        fill(16'h1000, 16'h0800);
        push_uniform(16'h1800);
        do_start();
        check("start_busy", CW'(busy), CW'(1));
        check("start_row_valid", CW'(row_valid), CW'(1));
        check("start_row_idx", CW'(row_idx), CW'(0));
        wait_done(n);
        check("pass_latency_cycles", CW'(n), CW'(16));
        check("done_busy_high", CW'(busy), CW'(1));
        check("done_row_valid_low", CW'(row_valid), CW'(0));
        finish_pass(16);

        // Saturation: 7000+2000 -> 7FFF, 9000+D000 -> 8000, FFFF+0001 -> 0000,
        // and last element 7FFF+8000 -> FFFF (no clamp); others 0100+0200 -> 0300.
        fill(16'h0100, 16'h0200);
        attn_in[0] = 16'h7000; x_in[0] = 16'h2000;
        attn_in[1] = 16'h9000; x_in[1] = 16'hD000;
        attn_in[2] = 16'hFFFF; x_in[2] = 16'h0001;
        attn_in[L*E-1] = Q15_MAX; x_in[L*E-1] = Q15_MIN;
        for (int r = 0; r < L; r++) begin
            d = {E{16'h0300}};
            if (r == 0) begin
                d[0] = 16'h7FFF; d[1] = 16'h8000; d[2] = 16'h0000;
            end
            if (r == L - 1) d[E-1] = 16'hFFFF;
            push_row(r, d);
        end
        do_start();
        wait_done(n);
        finish_pass(16);
`ifdef RESID_SAT_CNT_EN
        check("sat_count_two", CW'(sat_count), CW'(2));
`endif

        // Backpressure on row 3; row r carries r*0x0100 + 0x0010.
        for (int i = 0; i < L*E; i++) begin
            attn_in[i] = DW'((i / E) * 16'h0100);
            x_in[i]    = 16'h0010;
        end
        for (int r = 0; r < L; r++) push_row(r, {E{DW'(r * 16'h0100 + 16'h0010)}});
        do_start();
        wait_idx(3);
        row_ready = 1'b0;
        hold = row_data;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("stall_row_idx", CW'(row_idx), CW'(3));
            check("stall_row_data", row_data, hold);
            check("stall_row_valid", CW'(row_valid), CW'(1));
        end
        row_ready = 1'b1;
        wait_done(n);
        finish_pass(16);

        // Start while busy: recapture request during row 7 must be ignored.
        fill(16'h0200, 16'h0300);
        push_uniform(16'h0500);
        do_start();
        wait_idx(7);
        fill(16'h4000, 16'h4000);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        finish_pass(16);
        repeat (3) @(posedge clk);
        #1;
        check("no_recapture_busy", CW'(busy), CW'(0));
        check("no_extra_done", CW'(done_cnt), CW'(1));

        // Reset mid-stream at row 9, then a fresh pass from row 0.
        fill(16'h0001, 16'h0002);
        push_uniform(16'h0003);
        do_start();
        wait_idx(9);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_row_valid", CW'(row_valid), CW'(0));
        check("midrst_busy", CW'(busy), CW'(0));
        check("midrst_row_idx", CW'(row_idx), CW'(0));
        check("midrst_row_data", row_data, '0);
        rst = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_done", CW'(done_cnt), CW'(0));
        fill(16'h1111, 16'h2222);
        push_uniform(16'h3333);
        do_start();
        wait_done(n);
        check("restart_latency_cycles", CW'(n), CW'(16));
        finish_pass(16);

        // Inputs change right after capture; 0x0400 + 0x0400 must be streamed.
        fill(16'h0400, 16'h0400);
        push_uniform(16'h0800);
        do_start();
        fill(16'h7000, 16'h7000);
        wait_done(n);
        finish_pass(16);
`ifdef RESID_SAT_CNT_EN
        check("sat_count_zero", CW'(sat_count), CW'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
